mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings, grant codes and word width for the instruction/data SRAM arbiter.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_OUT_I = 2'b01,
        ARB_OUT_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection between the fetch and data ports; produces a one-hot grant.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_elig,
    input  logic       d_elig,
    input  logic       ptr_d,
    output logic [1:0] grant
);

    // Single eligible requester wins outright; a tie follows the pointer (1 = data).
    always_comb begin
        grant = GNT_NONE;
        case ({d_elig, i_elig})
            2'b01: grant = GNT_I;
            2'b10: grant = GNT_D;
            2'b11: begin
                if (ptr_d) begin
                    grant = GNT_D;
                end else begin
                    grant = GNT_I;
                end
            end
            default: grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-latency SRAM arbiter for instruction fetch and data ports.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [WORD_W-1:0] d_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [WORD_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic [WORD_W-1:0] sram_rdata
);

    arb_state_e  state_r;
    logic        run_r;
    logic        ptr_d_s;
    logic        i_elig_s;
    logic        d_elig_s;
    logic [1:0]  grant_s;

    // run_r holds off grants until the first rising edge after reset release.
    assign i_elig_s = run_r & i_req & (state_r != ARB_OUT_I);
    assign d_elig_s = run_r & d_req & (state_r != ARB_OUT_D);

    arb_pick u_pick (
        .i_elig (i_elig_s),
        .d_elig (d_elig_s),
        .ptr_d  (ptr_d_s),
        .grant  (grant_s)
    );

    // Drive the SRAM from the granted owner; all-zero when nothing is granted.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = {WORD_W{1'b0}};
        sram_wdata = {WORD_W{1'b0}};
        case (grant_s)
            GNT_D: begin
                sram_en    = 1'b1;
                sram_wen   = d_wen;
                sram_addr  = d_addr;
                sram_wdata = d_wdata;
            end
            GNT_I: begin
                sram_en    = 1'b1;
                sram_addr  = i_addr;
            end
            default: begin
                sram_en    = 1'b0;
            end
        endcase
    end

    // Track which access is outstanding; reset discards any in-flight access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ARB_IDLE;
            run_r   <= 1'b0;
        end else begin
            run_r <= 1'b1;
            case (grant_s)
                GNT_D:   state_r <= ARB_OUT_D;
                GNT_I:   state_r <= ARB_OUT_I;
                default: state_r <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_d_r;

    // After a tied grant the pointer names the requester that lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_d_r <= 1'b1;
        end else if (i_elig_s && d_elig_s) begin
            ptr_d_r <= (grant_s == GNT_I);
        end else begin
            ptr_d_r <= ptr_d_r;
        end
    end

    assign ptr_d_s = ptr_d_r;
`else
    assign ptr_d_s = 1'b1;
`endif

    assign i_rdy   = (state_r == ARB_OUT_I);
    assign d_rdy   = (state_r == ARB_OUT_D);
    assign i_rdata = i_rdy ? sram_rdata : {WORD_W{1'b0}};
    assign d_rdata = d_rdy ? sram_rdata : {WORD_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, write, contention, tie pointer and reset.
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rdy;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rdy;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdy      (i_rdy),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_wen      (d_wen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdy      (d_rdy),
        .d_rdata    (d_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] tie_addr;
        logic        tie_is_d;

        resetn     = 1'b0;
        i_req      = 1'b1;
        i_addr     = 32'h0000_1000;
        d_req      = 1'b1;
        d_wen      = 4'b1111;
        d_addr     = 32'h0000_2000;
        d_wdata    = 32'hFFFF_FFFF;
        sram_rdata = 32'h1234_5678;

        // Reset held with both requesting: everything quiet
        tick(); #1;
        chk1("rst_en", sram_en, 1'b0);
        chk1("rst_irdy", i_rdy, 1'b0);
        chk1("rst_drdy", d_rdy, 1'b0);
        chk32("rst_irdata", i_rdata, 32'h0);
        chk32("rst_drdata", d_rdata, 32'h0);
        chk32("rst_addr", sram_addr, 32'h0);
        chk1("rst_wen0", (sram_wen == 4'b0000), 1'b1);

        // Release between edges: no grant before the next rising edge
        resetn = 1'b1;
        #1;
        chk1("rel_no_early_grant", sram_en, 1'b0);
        i_req = 1'b0;
        d_req = 1'b0;

        // Fetch stream: one grant per two cycles
        tick();
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        #1;
        chk1("f_en0", sram_en, 1'b1);
        chk32("f_addr0", sram_addr, 32'hBFC0_0000);
        chk1("f_wen0", (sram_wen == 4'b0000), 1'b1);
        chk32("f_wdata0", sram_wdata, 32'h0);
        chk1("f_rdy0", i_rdy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            sram_rdata = 32'hA000_0000 + 32'(k);
            #1;
            chk1("f_rdy", i_rdy, 1'b1);
            chk32("f_rdata", i_rdata, 32'hA000_0000 + 32'(k));
            chk1("f_en_gap", sram_en, 1'b0);
            chk32("f_addr_gap", sram_addr, 32'h0);
            chk32("f_drdata", d_rdata, 32'h0);
            tick(); #1;
            chk1("f_en", sram_en, 1'b1);
            chk1("f_rdy_low", i_rdy, 1'b0);
            chk32("f_rdata_low", i_rdata, 32'h0);
        end
        tick();
        i_req = 1'b0;
        #1;
        chk1("f_last_rdy", i_rdy, 1'b1);
        tick(); #1;
        chk1("f_idle_en", sram_en, 1'b0);
        chk1("f_idle_rdy", i_rdy, 1'b0);

        // Partial write passes d_wen unmodified
        d_req   = 1'b1;
        d_wen   = 4'b0011;
        d_addr  = 32'h8000_0010;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        chk1("w_en", sram_en, 1'b1);
        chk1("w_wen", (sram_wen == 4'b0011), 1'b1);
        chk32("w_addr", sram_addr, 32'h8000_0010);
        chk32("w_wdata", sram_wdata, 32'hDEAD_BEEF);
        chk1("w_rdy_early", d_rdy, 1'b0);
        tick();
        sram_rdata = 32'h0;
        #1;
        chk1("w_rdy", d_rdy, 1'b1);
        chk32("w_rdata", d_rdata, 32'h0);
        chk1("w_en_gap", sram_en, 1'b0);
        d_req = 1'b0;
        tick(); #1;
        chk1("w_rdy_once", d_rdy, 1'b0);

        // Both requesting continuously: D, I, D, I, D with sram_en every cycle
        i_req      = 1'b1;
        i_addr     = 32'h0000_0100;
        d_req      = 1'b1;
        d_wen      = 4'b0000;
        d_addr     = 32'h0000_0200;
        d_wdata    = 32'h0000_0055;
        sram_rdata = 32'hCAFE_0000;
        #1;
        chk32("c_first_d", sram_addr, 32'h0000_0200);
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            chk1("c_en", sram_en, 1'b1);
            chk32("c_addr", sram_addr, (k % 2 == 1) ? 32'h0000_0100 : 32'h0000_0200);
            chk1("c_drdy", d_rdy, (k % 2 == 1));
            chk1("c_irdy", i_rdy, (k % 2 == 0));
            chk32("c_wdata", sram_wdata, (k % 2 == 1) ? 32'h0 : 32'h0000_0055);
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk1("c_end_drdy", d_rdy, 1'b1);
        chk32("c_end_drdata", d_rdata, 32'hCAFE_0000);
        chk1("c_end_en", sram_en, 1'b0);

        // Tie from idle after a tied data grant: pointer decides when round-robin is built in
`ifdef ARB_ROUND_ROBIN_EN
        tie_is_d = 1'b0;
        tie_addr = 32'h0000_0100;
`else
        tie_is_d = 1'b1;
        tie_addr = 32'h0000_0200;
`endif
        tick();
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        chk1("t_en", sram_en, 1'b1);
        chk32("t_addr", sram_addr, tie_addr);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk1("t_drdy", d_rdy, tie_is_d);
        chk1("t_irdy", i_rdy, !tie_is_d);
        tick(); #1;

        // Reset in the cycle after a data grant discards the access
        d_req  = 1'b1;
        d_addr = 32'h0000_0300;
        #1;
        chk1("r_grant_en", sram_en, 1'b1);
        chk32("r_grant_addr", sram_addr, 32'h0000_0300);
        tick();
        resetn = 1'b0;
        i_req  = 1'b1;
        sram_rdata = 32'h5A5A_5A5A;
        #1;
        chk1("r_no_drdy", d_rdy, 1'b0);
        chk32("r_drdata", d_rdata, 32'h0);
        chk1("r_en", sram_en, 1'b0);
        tick(); #1;
        chk1("r_hold_drdy", d_rdy, 1'b0);
        chk1("r_hold_irdy", i_rdy, 1'b0);
        resetn = 1'b1;
        #1;
        chk1("r_rel_en", sram_en, 1'b0);
        tick(); #1;
        chk1("r_first_en", sram_en, 1'b1);
        chk32("r_first_addr", sram_addr, 32'h0000_0300);
        chk1("r_no_stale_drdy", d_rdy, 1'b0);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk1("r_first_drdy", d_rdy, 1'b1);
        chk32("r_first_drdata", d_rdata, 32'h5A5A_5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
